// File: rtl/fpu_issue_seq.sv
// fpu_issue_seq: sequences one multi-cycle FPU operation at a time.
//
// An op is accepted in IDLE. Its operands, opcode and destination are latched,
// and the FPU gets a one-cycle start pulse on the first RUN cycle. The front end
// is stalled until the FPU answers. The result is then written back to the
// register file with a single-cycle strobe in WB.
//
// Optional feature: define FPU_TIMEOUT_EN to enable the RUN watchdog. When it
// fires, a quiet NaN is written back and err_timeout_o pulses.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   issue_valid_i/op/rd/a/b, issue_ready_o   decode-side handshake
//   flush_i             abort any in-flight op, block accept
//   fpu_start_o/op/a/b  launch pulse and stable operands to the FPU
//   fpu_done_i/result_i FPU completion pulse and result
//   stall_o             hold PC/decode
//   wb_valid_o/rd/data  register-file writeback
//   lat_cnt_o           RUN cycles of current/last op, saturating at MAX_LAT
//   err_timeout_o       watchdog pulse (tied low without FPU_TIMEOUT_EN)
module fpu_issue_seq #(
  parameter  int MAX_LAT = 16,
  localparam int CNT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_valid_i,
  input  logic [1:0]       issue_op_i,
  input  logic [4:0]       issue_rd_i,
  input  logic [31:0]      issue_a_i,
  input  logic [31:0]      issue_b_i,
  output logic             issue_ready_o,
  input  logic             flush_i,
  output logic             fpu_start_o,
  output logic [1:0]       fpu_op_o,
  output logic [31:0]      fpu_a_o,
  output logic [31:0]      fpu_b_o,
  input  logic             fpu_done_i,
  input  logic [31:0]      fpu_result_i,
  output logic             stall_o,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output logic [31:0]      wb_data_o,
  output logic [CNT_W-1:0] lat_cnt_o,
  output logic             err_timeout_o
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic       done_run;
  logic       timeout_hit;
  logic       to_flag;
  logic [4:0] rd_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_W'(MAX_LAT)) return CNT_W'(MAX_LAT);
    return v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    done_run      = 1'b0;
    timeout_hit   = 1'b0;
    issue_ready_o = (state == IDLE) && !flush_i;
    stall_o       = 1'b0;
    wb_valid_o    = 1'b0;
    err_timeout_o = 1'b0;
    case (state)
      IDLE: begin
        stall_o = issue_valid_i;
        if (issue_valid_i && !flush_i) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        stall_o = 1'b1;
        // Flush beats a same-cycle done; a done beats a same-cycle timeout.
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (fpu_done_i) begin
          done_run  = 1'b1;
          state_nxt = WB;
        end
`ifdef FPU_TIMEOUT_EN
        // The increment at this edge would make the count reach MAX_LAT.
        else if (lat_cnt_o == CNT_W'(MAX_LAT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = WB;
        end
`endif
      end
      WB: begin
        wb_valid_o    = !flush_i;
        err_timeout_o = to_flag;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FPU_TIMEOUT_EN
  // Remembers that WB was entered through the watchdog, not through a done.
  always_ff @(posedge clk_i) begin
    if (rst_i) to_flag <= 1'b0;
    else       to_flag <= timeout_hit;
  end
`else
  assign to_flag = 1'b0;
`endif

  // Operand/result latches and latency counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpu_start_o <= 1'b0;
      fpu_op_o    <= '0;
      fpu_a_o     <= '0;
      fpu_b_o     <= '0;
      rd_q        <= '0;
      wb_rd_o     <= '0;
      wb_data_o   <= '0;
      lat_cnt_o   <= '0;
    end else begin
      // Registered so the pulse lands on the first RUN cycle only.
      fpu_start_o <= accept;
      if (accept) begin
        fpu_op_o  <= issue_op_i;
        fpu_a_o   <= issue_a_i;
        fpu_b_o   <= issue_b_i;
        rd_q      <= issue_rd_i;
        lat_cnt_o <= '0;
      end
      if (state == RUN) lat_cnt_o <= sat_inc(lat_cnt_o);
      // wb_rd_o only moves when entering WB so it holds outside writeback.
      if (done_run) begin
        wb_data_o <= fpu_result_i;
        wb_rd_o   <= rd_q;
      end else if (timeout_hit) begin
        wb_data_o <= QNAN;
        wb_rd_o   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Directed testbench for fpu_issue_seq (MAX_LAT = 16).
module tb_fpu_issue_seq;

  localparam int CNT_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             issue_valid_i;
  logic [1:0]       issue_op_i;
  logic [4:0]       issue_rd_i;
  logic [31:0]      issue_a_i;
  logic [31:0]      issue_b_i;
  logic             issue_ready_o;
  logic             flush_i;
  logic             fpu_start_o;
  logic [1:0]       fpu_op_o;
  logic [31:0]      fpu_a_o;
  logic [31:0]      fpu_b_o;
  logic             fpu_done_i;
  logic [31:0]      fpu_result_i;
  logic             stall_o;
  logic             wb_valid_o;
  logic [4:0]       wb_rd_o;
  logic [31:0]      wb_data_o;
  logic [CNT_W-1:0] lat_cnt_o;
  logic             err_timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_issue_seq #(.MAX_LAT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_op_i(issue_op_i), .issue_rd_i(issue_rd_i),
    .issue_a_i(issue_a_i), .issue_b_i(issue_b_i), .issue_ready_o(issue_ready_o),
    .flush_i(flush_i),
    .fpu_start_o(fpu_start_o), .fpu_op_o(fpu_op_o), .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o),
    .fpu_done_i(fpu_done_i), .fpu_result_i(fpu_result_i),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .lat_cnt_o(lat_cnt_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, land 2 time units after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid_i = 1'b1;
    issue_op_i    = op;
    issue_rd_i    = rd;
    issue_a_i     = a;
    issue_b_i     = b;
  endtask

  initial begin
    rst_i = 1'b1; issue_valid_i = 1'b0; issue_op_i = '0; issue_rd_i = '0;
    issue_a_i = '0; issue_b_i = '0; flush_i = 1'b0; fpu_done_i = 1'b0; fpu_result_i = '0;
    cyc(); cyc();

    // Reset state
    chk("rst_ready", issue_ready_o, 1);
    chk("rst_stall", stall_o, 0);
    chk("rst_start", fpu_start_o, 0);
    chk("rst_wbv",   wb_valid_o, 0);
    chk("rst_wbd",   wb_data_o, 0);
    chk("rst_lat",   lat_cnt_o, 0);
    chk("rst_err",   err_timeout_o, 0);
    rst_i = 1'b0;
    cyc();

    // T1: add 1.0 + 2.0, done on the 4th RUN cycle
    issue(2'b00, 5'd5, 32'h3F80_0000, 32'h4000_0000);
    #1;
    chk("t1_ready", issue_ready_o, 1);
    chk("t1_stall_idle", stall_o, 1);
    cyc();                                   // RUN1
    issue_valid_i = 1'b0; #1;
    chk("t1_start", fpu_start_o, 1);
    chk("t1_a", fpu_a_o, 32'h3F80_0000);
    chk("t1_b", fpu_b_o, 32'h4000_0000);
    chk("t1_op", fpu_op_o, 0);
    chk("t1_ready_run", issue_ready_o, 0);
    chk("t1_lat1", lat_cnt_o, 0);
    cyc();                                   // RUN2
    chk("t1_start_once", fpu_start_o, 0);
    chk("t1_lat2", lat_cnt_o, 1);
    chk("t1_stall_run", stall_o, 1);
    cyc();                                   // RUN3
    cyc();                                   // RUN4
    fpu_done_i = 1'b1; fpu_result_i = 32'h4040_0000; #1;
    chk("t1_lat4", lat_cnt_o, 3);
    chk("t1_wbv_run", wb_valid_o, 0);
    cyc();                                   // WB
    fpu_done_i = 1'b0; fpu_result_i = 32'h1234_5678; #1;
    chk("t1_wbv", wb_valid_o, 1);
    chk("t1_wbrd", wb_rd_o, 5);
    chk("t1_wbd", wb_data_o, 32'h4040_0000);
    chk("t1_lat", lat_cnt_o, 4);
    chk("t1_stall_wb", stall_o, 0);
    chk("t1_ready_wb", issue_ready_o, 0);
    cyc();                                   // IDLE
    chk("t1_wbv_off", wb_valid_o, 0);
    chk("t1_wbd_hold", wb_data_o, 32'h4040_0000);
    chk("t1_ready_idle", issue_ready_o, 1);

    // T6 part: done pulse in IDLE is ignored
    fpu_done_i = 1'b1; fpu_result_i = 32'hBAD0_BAD0; #1;
    chk("t6_idle_stall", stall_o, 0);
    cyc();
    fpu_done_i = 1'b0; #1;
    chk("t6_idle_wbv", wb_valid_o, 0);
    chk("t6_idle_wbd", wb_data_o, 32'h4040_0000);
    chk("t6_idle_ready", issue_ready_o, 1);

    // T2: back-to-back, second op held with valid high; first op done on RUN1
    issue(2'b01, 5'd7, 32'h1111_1111, 32'h2222_2222);
    cyc();                                   // op1 RUN1
    issue(2'b10, 5'd9, 32'h3333_3333, 32'h4444_4444);
    fpu_done_i = 1'b1; fpu_result_i = 32'hAAAA_0001; #1;
    chk("t2_ready_run", issue_ready_o, 0);
    chk("t2_a1_stable", fpu_a_o, 32'h1111_1111);
    chk("t2_op1", fpu_op_o, 1);
    cyc();                                   // op1 WB
    fpu_done_i = 1'b0; #1;
    chk("t2_wbv1", wb_valid_o, 1);
    chk("t2_wbrd1", wb_rd_o, 7);
    chk("t2_wbd1", wb_data_o, 32'hAAAA_0001);
    chk("t2_lat1", lat_cnt_o, 1);
    chk("t2_stall_wb", stall_o, 0);
    chk("t2_ready_wb", issue_ready_o, 0);
    cyc();                                   // IDLE, op2 accepted here
    chk("t2_ready_idle", issue_ready_o, 1);
    chk("t2_stall_idle", stall_o, 1);
    chk("t2_wbv_idle", wb_valid_o, 0);
    cyc();                                   // op2 RUN1
    issue_valid_i = 1'b0;
    fpu_done_i = 1'b1; fpu_result_i = 32'hAAAA_0002; #1;
    chk("t2_start2", fpu_start_o, 1);
    chk("t2_a2", fpu_a_o, 32'h3333_3333);
    chk("t2_op2", fpu_op_o, 2);
    chk("t2_lat_clear", lat_cnt_o, 0);
    cyc();                                   // op2 WB
    fpu_done_i = 1'b0; #1;
    chk("t2_wbv2", wb_valid_o, 1);
    chk("t2_wbrd2", wb_rd_o, 9);
    chk("t2_wbd2", wb_data_o, 32'hAAAA_0002);
    cyc();                                   // IDLE

    // T6: done on first RUN cycle, rd = x0 still writes back on cycle 3
    issue(2'b00, 5'd0, 32'h5, 32'h6);
    cyc();                                   // cycle 2: RUN1
    issue_valid_i = 1'b0;
    fpu_done_i = 1'b1; fpu_result_i = 32'h0000_00F6; #1;
    chk("t6_wbv_run", wb_valid_o, 0);
    cyc();                                   // cycle 3: WB
    fpu_done_i = 1'b0; #1;
    chk("t6_wbv", wb_valid_o, 1);
    chk("t6_wbrd", wb_rd_o, 0);
    chk("t6_wbd", wb_data_o, 32'h0000_00F6);
    cyc();

    // T3: flush together with done in RUN
    issue(2'b00, 5'd3, 32'h7, 32'h8);
    cyc();                                   // RUN1
    issue_valid_i = 1'b0;
    cyc();                                   // RUN2
    flush_i = 1'b1; fpu_done_i = 1'b1; fpu_result_i = 32'hDEAD_BEEF; #1;
    chk("t3_wbv_run", wb_valid_o, 0);
    cyc();
    flush_i = 1'b0; fpu_done_i = 1'b0; #1;
    chk("t3_wbv", wb_valid_o, 0);
    chk("t3_ready", issue_ready_o, 1);
    chk("t3_stall", stall_o, 0);
    chk("t3_wbd_hold", wb_data_o, 32'h0000_00F6);
    cyc();
    chk("t3_wbv_late", wb_valid_o, 0);

    // Flush in IDLE blocks accept
    issue(2'b00, 5'd4, 32'h9, 32'hA);
    flush_i = 1'b1; #1;
    chk("fi_ready", issue_ready_o, 0);
    cyc();
    flush_i = 1'b0; issue_valid_i = 1'b0; #1;
    chk("fi_start", fpu_start_o, 0);
    chk("fi_ready_after", issue_ready_o, 1);
    chk("fi_a_not_latched", fpu_a_o, 32'h7);

    // Flush in WB gates the writeback
    issue(2'b00, 5'd4, 32'hB, 32'hC);
    cyc();
    issue_valid_i = 1'b0; fpu_done_i = 1'b1; fpu_result_i = 32'h0000_0C0C;
    cyc();                                   // WB
    fpu_done_i = 1'b0; flush_i = 1'b1; #1;
    chk("fw_wbv", wb_valid_o, 0);
    cyc();
    flush_i = 1'b0; #1;
    chk("fw_wbv_after", wb_valid_o, 0);
    chk("fw_ready", issue_ready_o, 1);

    // T4: reset mid-RUN
    issue(2'b11, 5'd6, 32'hCAFE_0000, 32'hF00D_0000);
    cyc();                                   // RUN1
    issue_valid_i = 1'b0;
    cyc();                                   // RUN2
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0; #1;
    chk("t4_start", fpu_start_o, 0);
    chk("t4_a", fpu_a_o, 0);
    chk("t4_op", fpu_op_o, 0);
    chk("t4_wbd", wb_data_o, 0);
    chk("t4_wbrd", wb_rd_o, 0);
    chk("t4_lat", lat_cnt_o, 0);
    chk("t4_stall", stall_o, 0);
    chk("t4_wbv", wb_valid_o, 0);
    fpu_done_i = 1'b1; fpu_result_i = 32'h5555_5555;
    cyc();
    fpu_done_i = 1'b0; #1;
    chk("t4_late_done_wbv", wb_valid_o, 0);
    cyc();
    chk("t4_late_done_wbv2", wb_valid_o, 0);
    chk("t4_late_done_wbd", wb_data_o, 0);

`ifdef FPU_TIMEOUT_EN
    // T5: no done, watchdog after 16 RUN cycles
    issue(2'b00, 5'd8, 32'h1, 32'h2);
    cyc();
    issue_valid_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("t5_lat", lat_cnt_o, k - 1);
      chk("t5_wbv_run", wb_valid_o, 0);
      cyc();
    end
    chk("t5_wbv", wb_valid_o, 1);
    chk("t5_wbd", wb_data_o, 32'h7FC0_0000);
    chk("t5_wbrd", wb_rd_o, 8);
    chk("t5_err", err_timeout_o, 1);
    chk("t5_lat_sat", lat_cnt_o, 16);
    cyc();
    chk("t5_err_once", err_timeout_o, 0);
    // Done on the timeout cycle wins
    issue(2'b00, 5'd10, 32'h1, 32'h2);
    cyc();
    issue_valid_i = 1'b0;
    repeat (15) cyc();
    fpu_done_i = 1'b1; fpu_result_i = 32'h4110_0000;
    cyc();
    fpu_done_i = 1'b0; #1;
    chk("t5r_wbv", wb_valid_o, 1);
    chk("t5r_wbd", wb_data_o, 32'h4110_0000);
    chk("t5r_err", err_timeout_o, 0);
    cyc();
`else
    // Without the watchdog RUN waits; the count saturates at 16
    issue(2'b00, 5'd8, 32'h1, 32'h2);
    cyc();
    issue_valid_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      chk("t5n_lat", lat_cnt_o, (k - 1 > 16) ? 16 : k - 1);
      chk("t5n_err", err_timeout_o, 0);
      chk("t5n_stall", stall_o, 1);
      cyc();
    end
    fpu_done_i = 1'b1; fpu_result_i = 32'h4110_0000;
    cyc();
    fpu_done_i = 1'b0; #1;
    chk("t5n_wbv", wb_valid_o, 1);
    chk("t5n_wbd", wb_data_o, 32'h4110_0000);
    chk("t5n_err_wb", err_timeout_o, 0);
    chk("t5n_lat_sat", lat_cnt_o, 16);
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
